trap_seq_ctrl: RTL and testbench

Sequencer and arbiter for the single-port machine CSR file. In the idle state it passes the core's Zicsr instruction accesses through to the CSR port. On a trap (ecall, ebreak or illegal instruction) or an mret, it takes the port for several cycles and runs the required CSR read-modify-write sequence. It then issues a one-cycle PC redirect to fetch. The core stalls while busy is high.

---
 rtl/trap_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_trap_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_seq_ctrl.sv
// Machine-mode CSR port sequencer: passes Zicsr accesses through when idle and
// runs the trap-entry / mret read-modify-write sequences, ending in a PC redirect.
module trap_seq_ctrl #(
  parameter int          XLEN         = 32,
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  input  logic [11:0]     core_csr_addr,
  input  logic [XLEN-1:0] core_csr_wdata,
  input  logic            core_csr_we,
  output logic            core_grant,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    T_MEPC    = 3'd1,
    T_MCAUSE  = 3'd2,
    T_MSTATUS = 3'd3,
    T_MTVEC   = 3'd4,
    M_MEPC    = 3'd5,
    M_MSTATUS = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic            latch_s;
  logic            redirect_load_s;
  logic [XLEN-1:0] redirect_next_s;
  logic            csr_we_s;
  logic            core_grant_s;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r        = v;
    r[7]     = v[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r        = v;
    r[3]     = v[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // State, latched trap info and redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cause_r       <= '0;
      pc_r          <= '0;
      redirect_pc_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (latch_s) begin
        cause_r <= trap_cause;
        pc_r    <= trap_pc;
      end
      if (redirect_load_s) begin
        redirect_pc_r <= redirect_next_s;
      end
    end
  end

  // Next-state and CSR port steering.
  always_comb begin
    state_next_s    = state_r;
    csr_addr        = core_csr_addr;
    csr_wdata       = core_csr_wdata;
    csr_we_s        = 1'b0;
    core_grant_s    = 1'b0;
    latch_s         = 1'b0;
    redirect_load_s = 1'b0;
    redirect_next_s = redirect_pc_r;
    case (state_r)
      IDLE: begin
        if (trap_req) begin
          latch_s      = 1'b1;
          state_next_s = T_MEPC;
        end else if (mret_req) begin
          state_next_s = M_MEPC;
        end else begin
          core_grant_s = 1'b1;
          csr_we_s     = core_csr_we;
        end
      end
      T_MEPC: begin
        csr_addr     = ADDR_MEPC;
        csr_wdata    = {pc_r[XLEN-1:2], 2'b00};
        csr_we_s     = 1'b1;
        state_next_s = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_addr     = ADDR_MCAUSE;
        csr_wdata    = cause_r;
        csr_we_s     = 1'b1;
        state_next_s = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = mstatus_on_trap(csr_rdata);
        csr_we_s     = 1'b1;
        state_next_s = T_MTVEC;
      end
      T_MTVEC: begin
        // Direct mode only: the mode field is discarded.
        csr_addr        = ADDR_MTVEC;
        redirect_load_s = 1'b1;
        redirect_next_s = {csr_rdata[XLEN-1:2], 2'b00};
        state_next_s    = DONE;
      end
      M_MEPC: begin
        csr_addr        = ADDR_MEPC;
        redirect_load_s = 1'b1;
        redirect_next_s = {csr_rdata[XLEN-1:2], 2'b00};
        state_next_s    = M_MSTATUS;
      end
      M_MSTATUS: begin
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = mstatus_on_mret(csr_rdata);
        csr_we_s     = 1'b1;
        state_next_s = DONE;
      end
      DONE: begin
        csr_addr     = ADDR_MSTATUS;
        state_next_s = IDLE;
      end
      default: begin
        csr_addr     = ADDR_MSTATUS;
        state_next_s = IDLE;
      end
    endcase
  end

  // A reset cycle aborts at once: no write, grant or redirect leaks out.
  assign csr_we         = csr_we_s & ~rst;
  assign core_grant     = core_grant_s & ~rst;
  assign busy           = (state_r != IDLE);
  assign redirect_valid = (state_r == DONE) & ~rst;
  assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Scoreboard bench for trap_seq_ctrl: a CSR file model answers reads, and every
// CSR write and redirect is popped from expected queues filled by the stimulus.
module tb_trap_seq_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_req;
  logic [11:0]     core_csr_addr;
  logic [XLEN-1:0] core_csr_wdata;
  logic            core_csr_we;
  logic            core_grant;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_we;
  logic [XLEN-1:0] csr_rdata;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [XLEN-1:0] m_mstatus = 32'h0, m_mtvec = 32'h0, m_mepc = 32'h0;
  logic [XLEN-1:0] m_mcause = 32'h0, m_other = 32'h0;

  logic [43:0]     wq[$];
  int              rq_cyc[$];
  logic [XLEN-1:0] rq_pc[$];
  logic [43:0]     wexp;
  int              rexp_cyc;
  logic [XLEN-1:0] rexp_pc;
  int              t0;

  trap_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_req(mret_req),
    .core_csr_addr(core_csr_addr), .core_csr_wdata(core_csr_wdata), .core_csr_we(core_csr_we),
    .core_grant(core_grant),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: combinational read, write on the clock edge.
  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = m_other;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: m_other   <= csr_wdata;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (csr_we) begin
      if (wq.size() == 0) begin
        check("spurious_wr", 64'(csr_we), 64'd0);
      end else begin
        wexp = wq.pop_front();
        check("csr_wr", 64'({csr_addr, csr_wdata}), 64'(wexp));
      end
    end
    if (redirect_valid) begin
      if (rq_pc.size() == 0) begin
        check("spurious_redirect", 64'(redirect_valid), 64'd0);
      end else begin
        rexp_cyc = rq_cyc.pop_front();
        rexp_pc  = rq_pc.pop_front();
        check("redirect_cyc", 64'(cyc), 64'(rexp_cyc));
        check("redirect_pc", 64'(redirect_pc), 64'(rexp_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [11:0] a, input logic [XLEN-1:0] d);
    core_csr_addr  = a;
    core_csr_wdata = d;
    core_csr_we    = 1'b1;
    wq.push_back({a, d});
    tick();
    core_csr_we = 1'b0;
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    wq.push_back({a, d});
  endtask

  task automatic exp_redirect(input int c, input logic [XLEN-1:0] pc);
    rq_cyc.push_back(c);
    rq_pc.push_back(pc);
  endtask

  initial begin
    trap_req = 1'b0; trap_cause = '0; trap_pc = '0; mret_req = 1'b0;
    core_csr_addr = 12'h0; core_csr_wdata = '0; core_csr_we = 1'b0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_csr_we", 64'(csr_we), 64'd0);
    rst = 1'b0;

    // Core pass-through write in IDLE
    core_csr_addr = 12'h305; core_csr_wdata = 32'h12345678; core_csr_we = 1'b1;
    exp_wr(12'h305, 32'h12345678);
    #1;
    check("pt_we", 64'(csr_we), 64'd1);
    check("pt_grant", 64'(core_grant), 64'd1);
    check("pt_addr", 64'(csr_addr), 64'h305);
    check("pt_busy", 64'(busy), 64'd0);
    tick();
    core_csr_we = 1'b0;
    core_write(12'h305, 32'h80000101);
    core_write(12'h300, 32'h00000008);

    // Trap: cause 11 at pc 0x80000010
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h80000010; t0 = cyc;
    exp_wr(12'h341, 32'h80000010);
    exp_wr(12'h342, 32'h0000000B);
    exp_wr(12'h300, 32'h00001880);
    exp_redirect(t0 + 5, 32'h80000100);
    #1;
    check("trap_req_grant", 64'(core_grant), 64'd0);
    tick();
    trap_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("trap_busy", 64'(busy), 64'd1);
      check("trap_no_grant", 64'(core_grant), 64'd0);
      tick();
    end
    check("trap_idle_busy", 64'(busy), 64'd0);

    // mret back to 0x80000010
    mret_req = 1'b1; t0 = cyc;
    exp_wr(12'h300, 32'h00001888);
    exp_redirect(t0 + 3, 32'h80000010);
    tick();
    mret_req = 1'b0;
    repeat (3) tick();

    // Trap, mret and core write together: trap wins, others dropped
    trap_req = 1'b1; mret_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h80000203;
    core_csr_addr = 12'h305; core_csr_wdata = 32'hDEAD0000; core_csr_we = 1'b1; t0 = cyc;
    exp_wr(12'h341, 32'h80000200);
    exp_wr(12'h342, 32'h00000002);
    exp_wr(12'h300, 32'h00001880);
    exp_redirect(t0 + 5, 32'h80000100);
    #1;
    check("combo_grant", 64'(core_grant), 64'd0);
    tick();
    trap_req = 1'b0; mret_req = 1'b0; core_csr_we = 1'b0;
    repeat (6) tick();

    // Second trap_req at T+2 is ignored
    trap_req = 1'b1; trap_cause = 32'd3; trap_pc = 32'h80000300; t0 = cyc;
    exp_wr(12'h341, 32'h80000300);
    exp_wr(12'h342, 32'h00000003);
    exp_wr(12'h300, 32'h00001800);
    exp_redirect(t0 + 5, 32'h80000100);
    tick();
    trap_req = 1'b0;
    tick();
    trap_req = 1'b1; trap_cause = 32'd7; trap_pc = 32'h80000700;
    tick();
    trap_req = 1'b0;
    repeat (5) tick();

    // Reset during T_MCAUSE aborts the sequence
    trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h80000400;
    exp_wr(12'h341, 32'h80000400);
    tick();
    trap_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_no_we", 64'(csr_we), 64'd0);
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_redirect_valid", 64'(redirect_valid), 64'd0);
    check("abort_redirect_pc", 64'(redirect_pc), 64'd0);
    repeat (8) tick();

    check("mcause_final", 64'(m_mcause), 64'h3);
    check("mstatus_final", 64'(m_mstatus), 64'h1800);
    check("mtvec_final", 64'(m_mtvec), 64'h80000101);
    check("wq_left", 64'(wq.size()), 64'd0);
    check("rq_left", 64'(rq_pc.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
